// File: rtl/keypad_scan_decoder.sv
// 4x4 matrix keypad scanner: active-low column drive, synchronised active-low rows,
// whole-scan debouncing and one key_valid strobe per accepted press (no rollover).
module keypad_scan_decoder #(
    parameter int SCAN_DIV_EXP   = 16,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] row_in,
    output logic [3:0] col_out,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held
);

    typedef enum logic [1:0] {
        KIND_NONE  = 2'd0,
        KIND_KEY   = 2'd1,
        KIND_MULTI = 2'd2
    } kind_e;

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_PRESSED = 1'b1
    } state_e;

    localparam logic [3:0]              STABLE_CNT = 4'(DEBOUNCE_SCANS);
    localparam logic [SCAN_DIV_EXP-1:0] PRESC_ONE  = {{(SCAN_DIV_EXP-1){1'b0}}, 1'b1};

    function automatic logic [2:0] count_pressed(input logic [3:0] p);
        count_pressed = {2'b00, p[0]} + {2'b00, p[1]} + {2'b00, p[2]} + {2'b00, p[3]};
    endfunction

    function automatic logic [1:0] lowest_row(input logic [3:0] p);
        if (p[0]) begin
            lowest_row = 2'd0;
        end else if (p[1]) begin
            lowest_row = 2'd1;
        end else if (p[2]) begin
            lowest_row = 2'd2;
        end else begin
            lowest_row = 2'd3;
        end
    endfunction

    logic [3:0]              row_meta_q, row_s_q;
    logic [SCAN_DIV_EXP-1:0] presc_q, presc_d;
    logic [1:0]              idx_q, idx_d;
    logic [3:0]              col_q, col_d;
    logic [1:0]              acc_cnt_q, acc_cnt_d;
    logic                    first_found_q, first_found_d;
    logic [3:0]              first_code_q, first_code_d;
    kind_e                   cand_kind_q, cand_kind_d;
    logic [3:0]              cand_code_q, cand_code_d;
    logic [3:0]              stab_cnt_q, stab_cnt_d;
    logic                    scan_done_q, scan_done_d;
    state_e                  state_q, state_d;
    logic [3:0]              key_code_q, key_code_d;
    logic                    key_valid_q, key_valid_d;
    logic                    key_held_q, key_held_d;

    logic                    tick_s;
    logic [3:0]              pressed_s;
    logic [1:0]              base_cnt_s;
    logic                    base_found_s;
    logic [2:0]              sum_s;
    kind_e                   res_kind_s;
    logic [3:0]              res_code_s;
    logic                    stable_s;

    assign tick_s    = &presc_q;
    assign pressed_s = ~row_s_q;
    assign stable_s  = (stab_cnt_q == STABLE_CNT);

    // Two-flop synchroniser for the asynchronous row inputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            row_meta_q <= 4'b1111;
            row_s_q    <= 4'b1111;
        end else begin
            row_meta_q <= row_in;
            row_s_q    <= row_meta_q;
        end
    end

    // Prescaler, column sequencing, per-scan accumulation and stability tracking
    always_comb begin
        presc_d       = presc_q + PRESC_ONE;
        idx_d         = idx_q;
        col_d         = col_q;
        acc_cnt_d     = acc_cnt_q;
        first_found_d = first_found_q;
        first_code_d  = first_code_q;
        cand_kind_d   = cand_kind_q;
        cand_code_d   = cand_code_q;
        stab_cnt_d    = stab_cnt_q;
        scan_done_d   = 1'b0;
        base_cnt_s    = 2'd0;
        base_found_s  = 1'b0;
        sum_s         = 3'd0;
        res_kind_s    = KIND_NONE;
        res_code_s    = 4'd0;
        if (tick_s) begin
            idx_d = idx_q + 2'd1;
            col_d = ~(4'b0001 << idx_d);
            if (idx_q == 2'd0) begin
                base_cnt_s   = 2'd0;
                base_found_s = 1'b0;
            end else begin
                base_cnt_s   = acc_cnt_q;
                base_found_s = first_found_q;
            end
            // Press count saturates at 2: only none/one/many matters
            sum_s     = {1'b0, base_cnt_s} + count_pressed(pressed_s);
            acc_cnt_d = (sum_s >= 3'd2) ? 2'd2 : sum_s[1:0];
            if (!base_found_s && (pressed_s != 4'b0000)) begin
                first_found_d = 1'b1;
                first_code_d  = {idx_q, lowest_row(pressed_s)};
            end else begin
                first_found_d = base_found_s;
                first_code_d  = first_code_q;
            end
            if (idx_q == 2'd3) begin
                scan_done_d = 1'b1;
                if (acc_cnt_d == 2'd0) begin
                    res_kind_s = KIND_NONE;
                    res_code_s = 4'd0;
                end else if (acc_cnt_d == 2'd2) begin
                    res_kind_s = KIND_MULTI;
                    res_code_s = 4'd0;
                end else begin
                    res_kind_s = KIND_KEY;
                    res_code_s = first_code_d;
                end
                if ((res_kind_s == cand_kind_q) && (res_code_s == cand_code_q)) begin
                    if (stab_cnt_q < STABLE_CNT) begin
                        stab_cnt_d = stab_cnt_q + 4'd1;
                    end else begin
                        stab_cnt_d = stab_cnt_q;
                    end
                end else begin
                    cand_kind_d = res_kind_s;
                    cand_code_d = res_code_s;
                    stab_cnt_d  = 4'd1;
                end
            end else begin
                scan_done_d = 1'b0;
            end
        end else begin
            idx_d = idx_q;
        end
    end

    // Scan and debounce state registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            presc_q       <= '0;
            idx_q         <= 2'd0;
            col_q         <= 4'b1110;
            acc_cnt_q     <= 2'd0;
            first_found_q <= 1'b0;
            first_code_q  <= 4'd0;
            cand_kind_q   <= KIND_NONE;
            cand_code_q   <= 4'd0;
            stab_cnt_q    <= 4'd0;
            scan_done_q   <= 1'b0;
        end else begin
            presc_q       <= presc_d;
            idx_q         <= idx_d;
            col_q         <= col_d;
            acc_cnt_q     <= acc_cnt_d;
            first_found_q <= first_found_d;
            first_code_q  <= first_code_d;
            cand_kind_q   <= cand_kind_d;
            cand_code_q   <= cand_code_d;
            stab_cnt_q    <= stab_cnt_d;
            scan_done_q   <= scan_done_d;
        end
    end

    // Press/release acceptance; the state only moves back to idle on a stable release
    always_comb begin
        state_d     = state_q;
        key_code_d  = key_code_q;
        key_held_d  = key_held_q;
        key_valid_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (scan_done_q && stable_s && (cand_kind_q == KIND_KEY)) begin
                    state_d     = ST_PRESSED;
                    key_code_d  = cand_code_q;
                    key_valid_d = 1'b1;
                    key_held_d  = 1'b1;
                end else begin
                    state_d    = ST_IDLE;
                    key_held_d = 1'b0;
                end
            end
            ST_PRESSED: begin
                if (scan_done_q && stable_s && (cand_kind_q == KIND_NONE)) begin
                    state_d    = ST_IDLE;
                    key_held_d = 1'b0;
                end else begin
                    state_d    = ST_PRESSED;
                    key_held_d = 1'b1;
                end
            end
            default: begin
                state_d    = ST_IDLE;
                key_held_d = 1'b0;
            end
        endcase
    end

    // Output state registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            key_code_q  <= 4'd0;
            key_valid_q <= 1'b0;
            key_held_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            key_code_q  <= key_code_d;
            key_valid_q <= key_valid_d;
            key_held_q  <= key_held_d;
        end
    end

    assign col_out   = col_q;
    assign key_code  = key_code_q;
    assign key_valid = key_valid_q;
    assign key_held  = key_held_q;

endmodule

// File: tb/tb_keypad_scan_decoder.sv
// Directed bench for keypad_scan_decoder with a keypad matrix model and a pulse scoreboard.
module tb_keypad_scan_decoder;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  row_in;
    logic [3:0]  col_out;
    logic [3:0]  key_code;
    logic        key_valid;
    logic        key_held;
    logic [15:0] key_down;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    typedef struct {
        logic [3:0] code;
        int         cyc;
    } exp_t;
    exp_t exp_q[$];

    keypad_scan_decoder #(
        .SCAN_DIV_EXP   (2),
        .DEBOUNCE_SCANS (4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .row_in    (row_in),
        .col_out   (col_out),
        .key_code  (key_code),
        .key_valid (key_valid),
        .key_held  (key_held)
    );

    always #5 clk = ~clk;

    // Keypad matrix: a pressed key pulls its row low while its column is driven
    always_comb begin
        row_in = 4'b1111;
        for (int c = 0; c < 4; c++) begin
            if (!col_out[c]) begin
                for (int r = 0; r < 4; r++) begin
                    if (key_down[c*4+r]) row_in[r] = 1'b0;
                end
            end
        end
    end

    always @(posedge clk) begin
        if (reset) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    // Scoreboard: every key_valid pulse must match the next expected press
    always @(negedge clk) begin
        if (!reset && key_valid) begin
            chk("pulse_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                exp_t e;
                e = exp_q.pop_front();
                chk("pulse_code", 32'(key_code), 32'(e.code));
                chk("pulse_held", 32'(key_held), 32'd1);
                if (e.cyc >= 0) chk("pulse_cycle", cyc, e.cyc);
            end
        end
    end

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_col"},   32'(col_out),   32'd14);
        chk({tag, "_code"},  32'(key_code),  32'd0);
        chk({tag, "_valid"}, 32'(key_valid), 32'd0);
        chk({tag, "_held"},  32'(key_held),  32'd0);
    endtask

    initial begin
        exp_t e;
        reset    = 1'b1;
        key_down = 16'h0000;
        wait_clks(3);
        chk_reset_vals("por");

        // Reset asserted mid-scan, then the column sequence after release
        reset    = 1'b0;
        key_down = 16'h0200;
        wait_clks(22);
        #1 reset = 1'b1;
        #1 chk_reset_vals("mid_scan_rst");
        key_down = 16'h0000;
        wait_clks(2);
        reset = 1'b0;
        chk("col_seq_0", 32'(col_out), 32'd14);
        for (int k = 1; k <= 16; k++) begin
            logic [3:0] one;
            logic [3:0] expc;
            @(negedge clk);
            one  = 4'b0001;
            expc = ~(one << ((k / 4) % 4));
            chk($sformatf("col_seq_%0d", k), 32'(col_out), 32'(expc));
        end

        // Clean hold of key 9 from reset release: pulse one clk after scan 4 ends
        reset = 1'b1;
        wait_clks(2);
        key_down = 16'h0200;
        e.code = 4'd9; e.cyc = 65; exp_q.push_back(e);
        reset = 1'b0;
        wait_clks(72);
        chk("clean_held", 32'(key_held), 32'd1);
        chk("clean_code", 32'(key_code), 32'd9);
        key_down = 16'h0000;
        wait_clks(32);
        chk("release_early_held", 32'(key_held), 32'd1);
        wait_clks(64);
        chk("release_held", 32'(key_held), 32'd0);
        chk("release_code", 32'(key_code), 32'd9);

        // Bounce on alternating scans: no pulse until four stable scans
        for (int i = 0; i < 6; i++) begin
            key_down = (i % 2 == 0) ? 16'h0200 : 16'h0000;
            wait_clks(16);
        end
        chk("bounce_held", 32'(key_held), 32'd0);
        e.code = 4'd9; e.cyc = -1; exp_q.push_back(e);
        key_down = 16'h0200;
        wait_clks(96);
        chk("bounce_after_held", 32'(key_held), 32'd1);
        key_down = 16'h0000;
        wait_clks(96);

        // Ghosting guard: two keys in different columns give no pulse
        key_down = 16'h8001;
        wait_clks(128);
        chk("multi_held", 32'(key_held), 32'd0);
        e.code = 4'd0; e.cyc = -1; exp_q.push_back(e);
        key_down = 16'h0001;
        wait_clks(96);
        chk("multi_resolved_held", 32'(key_held), 32'd1);
        chk("multi_resolved_code", 32'(key_code), 32'd0);
        key_down = 16'h0000;
        wait_clks(96);

        // No rollover: key 5 held, add 6, drop 5
        e.code = 4'd5; e.cyc = -1; exp_q.push_back(e);
        key_down = 16'h0020;
        wait_clks(96);
        key_down = 16'h0060;
        wait_clks(96);
        key_down = 16'h0040;
        wait_clks(96);
        chk("rollover_held", 32'(key_held), 32'd1);
        chk("rollover_code", 32'(key_code), 32'd5);
        key_down = 16'h0000;
        wait_clks(32);
        chk("rollover_rel_early", 32'(key_held), 32'd1);
        wait_clks(64);
        chk("rollover_rel_held", 32'(key_held), 32'd0);
        chk("rollover_rel_code", 32'(key_code), 32'd5);

        // Reset while PRESSED with the key still down
        e.code = 4'd9; e.cyc = -1; exp_q.push_back(e);
        key_down = 16'h0200;
        wait_clks(96);
        chk("pre_rst_held", 32'(key_held), 32'd1);
        @(negedge clk);
        #1 reset = 1'b1;
        #1 chk_reset_vals("pressed_rst");
        wait_clks(3);
        e.code = 4'd9; e.cyc = 65; exp_q.push_back(e);
        reset = 1'b0;
        wait_clks(80);
        chk("post_rst_held", 32'(key_held), 32'd1);
        chk("post_rst_code", 32'(key_code), 32'd9);

        chk("pulses_outstanding", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
